// File: rtl/rft_pkg.sv
// Shared types and helpers for the inverse RFT MAC core.
// Samples and kernel entries are signed Q1.15 complex values.
package rft_pkg;

    localparam int N_DEF  = 64;
    localparam int SW_DEF = 16;
    localparam int AW_DEF = 40;

    typedef enum logic [1:0] {
        LOAD,
        COMPUTE,
        OUTPUT
    } state_t;

    typedef struct packed {
        logic signed [SW_DEF-1:0] re;
        logic signed [SW_DEF-1:0] im;
    } cplx_t;

    // Returns {saturated, clamped Q1.15 value}.
    function automatic logic [SW_DEF:0] sat16(input logic signed [63:0] v);
        if (v > 64'sd32767) begin
            return {1'b1, 16'h7fff};
        end else if (v < -64'sd32768) begin
            return {1'b1, 16'h8000};
        end else begin
            return {1'b0, v[15:0]};
        end
    endfunction

endpackage

// File: rtl/rft_cmac.sv
// Registered complex multiply-accumulate with synchronous clear and enable.
// sum_* is the accumulator value including the current product.
module rft_cmac
    import rft_pkg::*;
#(
    parameter int ACC_WIDTH = AW_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        en,
    input  cplx_t                       a,
    input  cplx_t                       b,
    output logic signed [ACC_WIDTH-1:0] sum_re,
    output logic signed [ACC_WIDTH-1:0] sum_im
);

    logic signed [31:0]          p_rr, p_ii, p_ri, p_ir;
    logic signed [ACC_WIDTH-1:0] acc_re_q, acc_re_d;
    logic signed [ACC_WIDTH-1:0] acc_im_q, acc_im_d;

    assign p_rr = 32'(a.re) * 32'(b.re);
    assign p_ii = 32'(a.im) * 32'(b.im);
    assign p_ri = 32'(a.re) * 32'(b.im);
    assign p_ir = 32'(a.im) * 32'(b.re);

    always_comb begin
        sum_re = acc_re_q;
        sum_im = acc_im_q;
        if (en) begin
            sum_re = acc_re_q + ACC_WIDTH'(p_rr) - ACC_WIDTH'(p_ii);
            sum_im = acc_im_q + ACC_WIDTH'(p_ri) + ACC_WIDTH'(p_ir);
        end
        acc_re_d = clr ? '0 : sum_re;
        acc_im_d = clr ? '0 : sum_im;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_re_q <= '0;
            acc_im_q <= '0;
        end else begin
            acc_re_q <= acc_re_d;
            acc_im_q <= acc_im_d;
        end
    end

endmodule

// File: rtl/rft_inverse_mac_core.sv
// Inverse RFT synthesis core: x = U y, one complex MAC per cycle,
// kernel U streamed from an external ROM with one cycle of latency.
module rft_inverse_mac_core
    import rft_pkg::*;
#(
    parameter int N            = N_DEF,
    parameter int SAMPLE_WIDTH = SW_DEF,
    parameter int ACC_WIDTH    = AW_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic signed [SAMPLE_WIDTH-1:0] in_real,
    input  logic signed [SAMPLE_WIDTH-1:0] in_imag,
    output logic [2*$clog2(N)-1:0]         kern_addr,
    input  logic signed [15:0]             kern_real,
    input  logic signed [15:0]             kern_imag,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [SAMPLE_WIDTH-1:0] out_real,
    output logic signed [SAMPLE_WIDTH-1:0] out_imag,
    output logic                           out_last,
    output logic                           busy,
    output logic                           sat_flag
);

    localparam int          LG     = $clog2(N);
    localparam int          AD     = 2 * LG;
    localparam logic [LG-1:0] K_LAST = LG'(N - 1);
    localparam logic [LG:0] C_LAST = (LG + 1)'(N);
    localparam logic [LG:0] C_ADDR = (LG + 1)'(N - 1);

    state_t          st_q, st_d;
    logic [LG-1:0]   k_q, k_d;
    logic [LG-1:0]   n_q, n_d;
    logic [LG:0]     c_q, c_d;
    logic [AD-1:0]   addr_q, addr_d;
    logic            in_ready_q, in_ready_d;
    logic            busy_q, busy_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic            sat_q, sat_d;
    cplx_t           out_q, out_d;

    cplx_t           ybuf [N];
    cplx_t           yrd_q;
    cplx_t           kern;
    logic            mac_clr, mac_en;
    logic signed [ACC_WIDTH-1:0] sum_re, sum_im, sh_re, sh_im;
    logic [SW_DEF:0] sr, si;

    assign kern = {kern_real, kern_imag};

    // Buffer read runs one cycle ahead so y[k] lines up with U[n,k].
    always_ff @(posedge clk) begin
        if (st_q == LOAD && in_valid) begin
            ybuf[k_q] <= {in_real, in_imag};
        end
        yrd_q <= ybuf[c_q[LG-1:0]];
    end

    assign mac_clr = (st_q == COMPUTE) && (c_q == '0);
    assign mac_en  = (st_q == COMPUTE) && (c_q != '0);

    rft_cmac #(
        .ACC_WIDTH(ACC_WIDTH)
    ) u_cmac (
        .clk    (clk),
        .rst    (rst),
        .clr    (mac_clr),
        .en     (mac_en),
        .a      (yrd_q),
        .b      (kern),
        .sum_re (sum_re),
        .sum_im (sum_im)
    );

    assign sh_re = sum_re >>> (SAMPLE_WIDTH - 1);
    assign sh_im = sum_im >>> (SAMPLE_WIDTH - 1);
    assign sr    = sat16(64'(sh_re));
    assign si    = sat16(64'(sh_im));

    always_comb begin
        st_d        = st_q;
        k_d         = k_q;
        n_d         = n_q;
        c_d         = c_q;
        addr_d      = addr_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        sat_d       = sat_q;
        out_d       = out_q;
        unique case (st_q)
            LOAD: begin
                if (in_valid) begin
                    k_d = k_q + 1'b1;
                    if (k_q == '0) begin
                        sat_d = 1'b0;
                    end
                    if (k_q == K_LAST) begin
                        st_d       = COMPUTE;
                        k_d        = '0;
                        n_d        = '0;
                        c_d        = '0;
                        addr_d     = '0;
                        in_ready_d = 1'b0;
                        busy_d     = 1'b1;
                    end
                end
            end
            COMPUTE: begin
                c_d = c_q + 1'b1;
                if (c_q < C_ADDR) begin
                    addr_d = addr_q + 1'b1;
                end
                if (c_q == C_LAST) begin
                    st_d        = OUTPUT;
                    c_d         = '0;
                    out_valid_d = 1'b1;
                    out_last_d  = (n_q == K_LAST);
                    out_d.re    = sr[SW_DEF-1:0];
                    out_d.im    = si[SW_DEF-1:0];
                    sat_d       = sat_q | sr[SW_DEF] | si[SW_DEF];
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (n_q == K_LAST) begin
                        st_d       = LOAD;
                        n_d        = '0;
                        in_ready_d = 1'b1;
                        busy_d     = 1'b0;
                    end else begin
                        st_d   = COMPUTE;
                        n_d    = n_q + 1'b1;
                        c_d    = '0;
                        addr_d = {n_q + 1'b1, {LG{1'b0}}};
                    end
                end
            end
            default: begin
                st_d = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q        <= LOAD;
            k_q         <= '0;
            n_q         <= '0;
            c_q         <= '0;
            addr_q      <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            sat_q       <= 1'b0;
            out_q       <= '0;
        end else begin
            st_q        <= st_d;
            k_q         <= k_d;
            n_q         <= n_d;
            c_q         <= c_d;
            addr_q      <= addr_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            sat_q       <= sat_d;
            out_q       <= out_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign sat_flag  = sat_q;
    assign kern_addr = addr_q;
    assign out_real  = out_q.re;
    assign out_imag  = out_q.im;

endmodule

// File: doc/rft_inverse_mac_core.md
RFT_INVERSE_MAC_CORE -- requirements
Module: rft_inverse_mac_core

Interface
REQ-001 Parameter N, default 64, transform length (power of 2, 4..256).
REQ-002 Parameter SAMPLE_WIDTH, default 16, Q1.15 sample/coefficient width.
REQ-003 Parameter ACC_WIDTH, default 40, signed accumulator width (>= 2*SAMPLE_WIDTH+1+log2(N)).
REQ-004 clk  in  1  single clock, all logic posedge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  coefficient y[k] valid.
REQ-007 in_ready  out  1  core accepts coefficient.
REQ-008 in_real, in_imag  in  SAMPLE_WIDTH each  signed Q1.15 y[k], k in arrival order 0..N-1.
REQ-009 kern_addr  out  log2(N*N)  kernel ROM address, U[n,k] stored at n*N+k.
REQ-010 kern_real, kern_imag  in  16 each  signed Q1.15 U[n,k], valid exactly 1 cycle after kern_addr.
REQ-011 out_valid  out  1  reconstructed sample x[n] valid.
REQ-012 out_ready  in  1  sink accepts sample.
REQ-013 out_real, out_imag  out  SAMPLE_WIDTH each  signed Q1.15 x[n], n ascending.
REQ-014 out_last  out  1  high with x[N-1].
REQ-015 busy  out  1  high in any state except LOAD.
REQ-016 sat_flag  out  1  sticky: some x[n] of current block saturated.

Function
REQ-017 Core computes x = U y (synthesis, inverse of y = U^H x): x[n] = sum_k U[n,k]*y[k], complex.
REQ-018 States: LOAD, COMPUTE, OUTPUT; one FSM.
REQ-019 LOAD: in_ready=1; transfer on in_valid&in_ready; y[k] written to N-entry buffer, k counter increments; gaps in in_valid allowed.
REQ-020 First transfer of a block clears sat_flag.
REQ-021 Transfer of k=N-1 -> COMPUTE next cycle with n=0, accumulators cleared; in_ready=0 outside LOAD.
REQ-022 COMPUTE: one complex MAC per cycle; kern_addr=n*N+k issued cycles 0..N-1, products accumulated cycles 1..N; COMPUTE lasts exactly N+1 cycles per n.
REQ-023 Product (a+jb)(c+jd) = (ac-bd) + j(ad+bc), 32-bit products, sign-extended to ACC_WIDTH, no intermediate rounding.
REQ-024 Result = acc >>> 15 (arithmetic, truncation); if outside [-32768,32767] clamp to bound and set sat_flag.
REQ-025 COMPUTE end -> OUTPUT: out_valid=1, out_real/imag/out_last registered and stable until out_valid&out_ready.
REQ-026 OUTPUT handshake: n<N-1 -> COMPUTE with n+1; n=N-1 -> LOAD.
REQ-027 out_ready may be held low indefinitely; no sample lost or duplicated; in_valid outside LOAD ignored.
REQ-028 kern_addr holds last value outside COMPUTE; kern_* inputs ignored outside COMPUTE.
REQ-029 Steady-state block time: N input cycles + N*(N+2) cycles with out_ready constantly high.

Reset
REQ-030 rst high at any clock edge, including mid-COMPUTE/OUTPUT: next state LOAD, counters 0, accumulators 0.
REQ-031 Reset values: in_ready=1 after reset release, out_valid=0, out_last=0, out_real=out_imag=0, kern_addr=0, busy=0, sat_flag=0.
REQ-032 Coefficient buffer contents not reset; block after reset fully reloaded before use.

Structure
REQ-033 Package rft_pkg holds N/SAMPLE_WIDTH/ACC_WIDTH defaults, state enum (LOAD, COMPUTE, OUTPUT), Q1.15 complex struct type, sat16 helper function.
REQ-034 One sub-module rft_cmac: registered complex multiply-accumulate with clear and enable, ACC_WIDTH output.
REQ-035 Kernel ROM is external; core contains no transform constants.

Verification
REQ-036 Identity kernel (U[n,n]=0x7FFF, else 0), y[k]=256k real, 0 imag -> x[0]=0, x[n]=256n-1 real, imag 0, sat_flag=0, out_last only at n=63.
REQ-037 Kernel U[n,n]=j*0x7FFF, y[k]=0x4000 real -> out_imag=0x3FFF, out_real=0 for all n.
REQ-038 All kernel real 0x7FFF, all y=0x7FFF -> every out_real=32767, sat_flag=1; next block of zeros clears sat_flag at first transfer, outputs 0.
REQ-039 out_ready low 20 cycles at n=5 -> out_valid held, data stable, exactly 64 outputs in order; in_valid toggling every cycle during LOAD -> exactly 64 coefficients accepted.
REQ-040 rst pulsed 1 cycle during COMPUTE of n=10 -> next cycle out_valid=0, busy=0, in_ready=1; following identity block reproduces REQ-036 results.
REQ-041 Random unitary kernel and random y, compared against host golden model (same truncation/saturation) -> bit-exact match on all 64 samples.
